vrc7_irq: RTL and testbench

VRC7 (mapper 85) IRQ generator: 8-bit reloadable up-counter driven by either every CPU cycle or a scanline-equivalent prescaler (341 ÷ 3 CPU cycles). Instantiated inside the mapper-85 core, which decodes CPU writes to the IRQ registers ($E010, $F000, $F010) and forwards the `irq` output into its map_out bundle. All state is synchronous to the single system clock. CPU timing arrives as a one-clock `cpu_ce` strobe per M2 cycle.

---
 rtl/vrc7_irq.sv | 84 ++++++++
 tb/tb_vrc7_irq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrc7_irq.sv
// VRC7 (mapper 85) IRQ generator: 8-bit reloadable up-counter clocked either
// every CPU cycle or by a 341/3 scanline-equivalent prescaler.
module vrc7_irq #(
    parameter int PRESC_RELOAD = 341,
    parameter int PRESC_STEP   = 3
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       cpu_ce,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_din,
    output logic       irq,
    output logic [7:0] irq_cnt
);

    localparam logic [8:0] RELOAD = 9'(PRESC_RELOAD);
    localparam logic [8:0] STEP   = 9'(PRESC_STEP);

    logic [7:0] latch;
    logic [7:0] cnt;
    logic [8:0] presc;
    logic       ctl_a;
    logic       ctl_e;
    logic       ctl_m;

    logic tick;
    logic presc_wrap;
    logic cnt_clk;

    // A register write in the same clk swallows the CPU tick completely.
    assign tick       = cpu_ce && ctl_e && !reg_we;
    assign presc_wrap = (presc <= STEP);
    assign cnt_clk    = tick && (ctl_m || presc_wrap);

    assign irq_cnt = cnt;

    always_ff @(posedge clk) begin
        if (map_rst) begin
            latch <= 8'h00;
            cnt   <= 8'h00;
            presc <= RELOAD;
            ctl_a <= 1'b0;
            ctl_e <= 1'b0;
            ctl_m <= 1'b0;
            irq   <= 1'b0;
        end else if (reg_we) begin
            case (reg_sel)
                2'd0: latch <= reg_din;
                2'd1: begin
                    ctl_a <= reg_din[0];
                    ctl_e <= reg_din[1];
                    ctl_m <= reg_din[2];
                    irq   <= 1'b0;
                    if (reg_din[1]) begin
                        cnt   <= latch;
                        presc <= RELOAD;
                    end
                end
                2'd2: begin
                    irq   <= 1'b0;
                    ctl_e <= ctl_a;
                end
                default: ;
            endcase
        end else if (tick) begin
            // Prescaler keeps running in cycle mode too; its value only matters in scanline mode.
            if (presc_wrap) begin
                presc <= presc + RELOAD - STEP;
            end else begin
                presc <= presc - STEP;
            end
            if (cnt_clk) begin
                if (cnt == 8'hFF) begin
                    cnt <= latch;
                    irq <= 1'b1;
                end else begin
                    cnt <= cnt + 8'h01;
                end
            end
        end
    end

endmodule

// File: tb/tb_vrc7_irq.sv
// Self-checking bench for vrc7_irq: directed scenarios plus random traffic,
// all compared against a tick-counting behavioural model.
module tb_vrc7_irq;

    logic       clk = 1'b0;
    logic       map_rst;
    logic       cpu_ce;
    logic       reg_we;
    logic [1:0] reg_sel;
    logic [7:0] reg_din;
    logic       irq;
    logic [7:0] irq_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: scanline clocks are derived from the total dot count since reload.
    logic [7:0] m_latch;
    logic [7:0] m_cnt;
    int         m_ticks;
    bit         m_a, m_e, m_m, m_irq;

    always #5 clk = ~clk;

    vrc7_irq dut (
        .clk     (clk),
        .map_rst (map_rst),
        .cpu_ce  (cpu_ce),
        .reg_we  (reg_we),
        .reg_sel (reg_sel),
        .reg_din (reg_din),
        .irq     (irq),
        .irq_cnt (irq_cnt)
    );

    task automatic model_update(input bit rst, input bit we, input logic [1:0] sel,
                                input logic [7:0] din, input bit ce);
        bit clock_evt;
        if (rst) begin
            m_latch = 8'h00; m_cnt = 8'h00; m_ticks = 0;
            m_a = 0; m_e = 0; m_m = 0; m_irq = 0;
        end else if (we) begin
            if (sel == 2'd0) m_latch = din;
            else if (sel == 2'd1) begin
                m_a = din[0]; m_e = din[1]; m_m = din[2]; m_irq = 0;
                if (din[1]) begin
                    m_cnt = m_latch;
                    m_ticks = 0;
                end
            end else if (sel == 2'd2) begin
                m_irq = 0;
                m_e = m_a;
            end
        end else if (ce && m_e) begin
            m_ticks++;
            clock_evt = m_m || ((3 * m_ticks) / 341 != (3 * (m_ticks - 1)) / 341);
            if (clock_evt) begin
                if (m_cnt == 8'hFF) begin
                    m_cnt = m_latch;
                    m_irq = 1;
                end else begin
                    m_cnt = m_cnt + 8'h01;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit we, input logic [1:0] sel,
                        input logic [7:0] din, input bit ce);
        map_rst = rst; reg_we = we; reg_sel = sel; reg_din = din; cpu_ce = ce;
        @(posedge clk);
        model_update(rst, we, sel, din, ce);
        #1;
        map_rst = 0; reg_we = 0; cpu_ce = 0;
    endtask

    task automatic tick();
        step(0, 0, 2'd0, 8'h00, 1);
        step(0, 0, 2'd0, 8'h00, 0);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] din);
        step(0, 1, sel, din, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
            checks++;
            if (irq !== 1'b0 || irq_cnt !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_hold: irq=%0b cnt=%02h, want irq=0 cnt=00", irq, irq_cnt);
            end
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (irq !== 1'b0 || irq_cnt !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_idle tick %0d: irq=%0b cnt=%02h, want irq=0 cnt=00", i, irq, irq_cnt);
            end
        end
    endtask

    task automatic test_cycle_overflow();
        wr(2'd0, 8'hFE);
        wr(2'd1, 8'h07);
        checks++;
        if (irq_cnt !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL cycle_load: cnt=%02h, want FE", irq_cnt);
        end
        tick();
        checks++;
        if (irq_cnt !== 8'hFF || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cycle_tick1: irq=%0b cnt=%02h, want irq=0 cnt=FF", irq, irq_cnt);
        end
        tick();
        checks++;
        if (irq_cnt !== 8'hFE || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cycle_overflow: irq=%0b cnt=%02h, want irq=1 cnt=FE", irq, irq_cnt);
        end
        wr(2'd2, 8'h00);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cycle_ack: irq=%0b, want 0", irq);
        end
        tick();
        checks++;
        if (irq_cnt !== 8'hFF || irq_cnt !== m_cnt) begin
            errors++;
            $display("[TB] FAIL cycle_after_ack: cnt=%02h, want FF (still enabled)", irq_cnt);
        end
    endtask

    task automatic test_scanline();
        int gaps[3] = '{114, 114, 113};
        int count;
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'h03);
        for (int g = 0; g < 3; g++) begin
            count = 0;
            while (irq !== 1'b1 && count < 200) begin
                tick();
                count++;
                checks++;
                if (irq !== m_irq || irq_cnt !== m_cnt) begin
                    errors++;
                    $display("[TB] FAIL scan_track g%0d t%0d: irq=%0b cnt=%02h, want irq=%0b cnt=%02h",
                             g, count, irq, irq_cnt, m_irq, m_cnt);
                end
            end
            checks++;
            if (count != gaps[g] || irq_cnt !== 8'hFF) begin
                errors++;
                $display("[TB] FAIL scan_gap%0d: ticks=%0d cnt=%02h, want ticks=%0d cnt=FF",
                         g, count, irq_cnt, gaps[g]);
            end
            wr(2'd2, 8'h00);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL scan_ack%0d: irq=%0b, want 0", g, irq);
            end
        end
    endtask

    task automatic test_ack_no_a();
        int count = 0;
        wr(2'd0, 8'hFD);
        wr(2'd1, 8'h06);
        while (irq !== 1'b1 && count < 10) begin
            tick();
            count++;
        end
        checks++;
        if (count != 3 || irq_cnt !== 8'hFD) begin
            errors++;
            $display("[TB] FAIL noa_overflow: ticks=%0d cnt=%02h, want ticks=3 cnt=FD", count, irq_cnt);
        end
        wr(2'd2, 8'h00);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL noa_ack: irq=%0b, want 0", irq);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (irq_cnt !== 8'hFD || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL noa_frozen: irq=%0b cnt=%02h, want irq=0 cnt=FD", irq, irq_cnt);
        end
    endtask

    task automatic test_collision();
        int count = 0;
        wr(2'd0, 8'h10);
        wr(2'd1, 8'h07);
        step(0, 1, 2'd0, 8'h55, 1);
        checks++;
        if (irq_cnt !== 8'h10) begin
            errors++;
            $display("[TB] FAIL collide_drop: cnt=%02h, want 10", irq_cnt);
        end
        tick();
        checks++;
        if (irq_cnt !== 8'h11) begin
            errors++;
            $display("[TB] FAIL collide_next: cnt=%02h, want 11", irq_cnt);
        end
        while (irq !== 1'b1 && count < 300) begin
            tick();
            count++;
        end
        checks++;
        if (count != 239 || irq_cnt !== 8'h55) begin
            errors++;
            $display("[TB] FAIL collide_latch: ticks=%0d cnt=%02h, want ticks=239 cnt=55", count, irq_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int count = 0;
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'h03);
        for (int i = 0; i < 164; i++) tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre: irq=%0b, want 1", irq);
        end
        step(1, 0, 2'd0, 8'h00, 0);
        checks++;
        if (irq !== 1'b0 || irq_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_reset: irq=%0b cnt=%02h, want irq=0 cnt=00", irq, irq_cnt);
        end
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'h02);
        while (irq !== 1'b1 && count < 200) begin
            tick();
            count++;
        end
        checks++;
        if (count != 114) begin
            errors++;
            $display("[TB] FAIL mid_reenable: ticks=%0d, want 114", count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 6) == 0, 2'($urandom), 8'($urandom),
                 1'($urandom));
            checks++;
            if (irq !== m_irq || irq_cnt !== m_cnt) begin
                errors++;
                $display("[TB] FAIL random c%0d: irq=%0b cnt=%02h, want irq=%0b cnt=%02h",
                         i, irq, irq_cnt, m_irq, m_cnt);
            end
        end
    endtask

    initial begin
        map_rst = 0; reg_we = 0; cpu_ce = 0; reg_sel = 2'd0; reg_din = 8'h00;
        model_update(1, 0, 2'd0, 8'h00, 0);
        test_reset();
        test_cycle_overflow();
        step(1, 0, 2'd0, 8'h00, 0);
        test_scanline();
        step(1, 0, 2'd0, 8'h00, 0);
        test_ack_no_a();
        step(1, 0, 2'd0, 8'h00, 0);
        test_collision();
        step(1, 0, 2'd0, 8'h00, 0);
        test_reset_mid();
        step(1, 0, 2'd0, 8'h00, 0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
